// File: rtl/encoder_frame_sched.sv
// Frame-granular round-robin scheduler sharing one FEC encoder between two message FIFOs.
// A granted channel streams a whole frame through a 2-entry skid buffer before the next grant.
module encoder_frame_sched #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAME_LEN  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sched_en,
  input  logic                  ch0_empty,
  output logic                  ch0_rd_en,
  input  logic [DATA_WIDTH-1:0] ch0_rd_data,
  input  logic                  ch0_rd_valid,
  input  logic                  ch1_empty,
  output logic                  ch1_rd_en,
  input  logic [DATA_WIDTH-1:0] ch1_rd_data,
  input  logic                  ch1_rd_valid,
  output logic                  enc_valid,
  input  logic                  enc_ready,
  output logic [DATA_WIDTH-1:0] enc_data,
  output logic                  enc_chan,
  output logic                  enc_sof,
  output logic                  enc_eof,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frames0_cnt,
  output logic [CNT_WIDTH-1:0]  frames1_cnt
);

  localparam int unsigned IDX_W = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eof;
    logic                  chan;
  } entry_t;

  state_e               state_q;
  logic                 cur_chan_q;
  logic                 last_grant_q;
  logic                 inflight_q;
  logic [IDX_W-1:0]     issued_q;
  logic [IDX_W-1:0]     rcv_q;
  logic [1:0]           occ_q;
  entry_t               skid_q [2];
  logic [CNT_WIDTH-1:0] frames0_q;
  logic [CNT_WIDTH-1:0] frames1_q;

  logic   accept;
  logic   cur_empty;
  logic   cur_valid;
  logic   room;
  logic   rd_en;
  logic   push;
  logic   gnt_req;
  logic   gnt_chan;
  entry_t push_word;

  // Pop gating: never let buffered plus in-flight words exceed the skid depth.
  always_comb begin
    accept         = (occ_q != 2'd0) && enc_ready;
    cur_empty      = cur_chan_q ? ch1_empty : ch0_empty;
    cur_valid      = cur_chan_q ? ch1_rd_valid : ch0_rd_valid;
    room           = (3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(accept));
    rd_en          = (state_q == XFER) && !cur_empty && (issued_q < FULL_IDX) && room;
    push           = inflight_q && cur_valid;
    push_word.data = cur_chan_q ? ch1_rd_data : ch0_rd_data;
    push_word.sof  = (rcv_q == '0);
    push_word.eof  = (rcv_q == LAST_IDX);
    push_word.chan = cur_chan_q;
    gnt_req        = sched_en && !(ch0_empty && ch1_empty);
    gnt_chan       = (!ch0_empty && !ch1_empty) ? !last_grant_q : ch0_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_chan_q   <= 1'b0;
      last_grant_q <= 1'b1;
      inflight_q   <= 1'b0;
      issued_q     <= '0;
      rcv_q        <= '0;
      occ_q        <= 2'd0;
      skid_q[0]    <= '0;
      skid_q[1]    <= '0;
      frames0_q    <= '0;
      frames1_q    <= '0;
    end else begin
      inflight_q <= rd_en;
      if (rd_en) issued_q <= issued_q + IDX_W'(1);
      if (push)  rcv_q    <= rcv_q + IDX_W'(1);

      // Skid buffer: entry 0 is the head presented to the encoder.
      case ({push, accept})
        2'b10: begin
          skid_q[occ_q[0]] <= push_word;
          occ_q            <= occ_q + 2'd1;
        end
        2'b01: begin
          skid_q[0] <= skid_q[1];
          occ_q     <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            skid_q[0] <= push_word;
          end else begin
            skid_q[0] <= skid_q[1];
            skid_q[1] <= push_word;
          end
        end
        default: ;
      endcase

      case (state_q)
        IDLE: begin
          if (gnt_req) begin
            cur_chan_q <= gnt_chan;
            issued_q   <= '0;
            rcv_q      <= '0;
            state_q    <= XFER;
          end
        end
        XFER: begin
          if (rd_en && (issued_q == LAST_IDX)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (accept && skid_q[0].eof) begin
            last_grant_q <= cur_chan_q;
            if (cur_chan_q) frames1_q <= frames1_q + CNT_WIDTH'(1);
            else            frames0_q <= frames0_q + CNT_WIDTH'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch0_rd_en   = rd_en && !cur_chan_q;
  assign ch1_rd_en   = rd_en && cur_chan_q;
  assign enc_valid   = (occ_q != 2'd0);
  assign enc_data    = skid_q[0].data;
  assign enc_sof     = skid_q[0].sof;
  assign enc_eof     = skid_q[0].eof;
  assign enc_chan    = skid_q[0].chan;
  assign busy        = (state_q != IDLE);
  assign frames0_cnt = frames0_q;
  assign frames1_cnt = frames1_q;

endmodule

// File: tb/tb_encoder_frame_sched.sv
// Directed bench for encoder_frame_sched: FIFO models on both channels and an in-order
// stream scoreboard driven from a single linear stimulus sequence.
module tb_encoder_frame_sched;

  localparam int DW = 32;
  localparam int FL = 16;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          sched_en;
  logic          ch0_empty, ch0_rd_en, ch0_rd_valid;
  logic          ch1_empty, ch1_rd_en, ch1_rd_valid;
  logic [DW-1:0] ch0_rd_data, ch1_rd_data;
  logic          enc_valid, enc_ready, enc_chan, enc_sof, enc_eof, busy;
  logic [DW-1:0] enc_data;
  logic [CW-1:0] frames0_cnt, frames1_cnt;

  encoder_frame_sched #(
    .DATA_WIDTH(DW),
    .FRAME_LEN (FL),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sched_en    (sched_en),
    .ch0_empty   (ch0_empty),
    .ch0_rd_en   (ch0_rd_en),
    .ch0_rd_data (ch0_rd_data),
    .ch0_rd_valid(ch0_rd_valid),
    .ch1_empty   (ch1_empty),
    .ch1_rd_en   (ch1_rd_en),
    .ch1_rd_data (ch1_rd_data),
    .ch1_rd_valid(ch1_rd_valid),
    .enc_valid   (enc_valid),
    .enc_ready   (enc_ready),
    .enc_data    (enc_data),
    .enc_chan    (enc_chan),
    .enc_sof     (enc_sof),
    .enc_eof     (enc_eof),
    .busy        (busy),
    .frames0_cnt (frames0_cnt),
    .frames1_cnt (frames1_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int            n_cmp;
  int            n_err;
  int            cyc;
  int            outstanding;
  int            widx;
  int            first_sof_cyc;
  int            last_eof_cyc;
  int            last_gap;
  int            t0;
  int            k;
  bit            saw_rd1;
  bit            stall_prev;
  logic [34:0]   stall_word;
  logic [DW-1:0] q0[$], q1[$], e0[$], e1[$];
  int            order[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int ch, input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (ch == 0) begin q0.push_back(w); e0.push_back(w); end
      else         begin q1.push_back(w); e1.push_back(w); end
    end
    ch0_empty = (q0.size() == 0);
    ch1_empty = (q1.size() == 0);
  endtask

  // One clock: sample before the edge, then update the FIFO models after it.
  task automatic cycle();
    logic          rd0, rd1, acc;
    logic [34:0]   word, expw;
    logic [DW-1:0] ed;
    int            ch;
    #1;
    rd0  = ch0_rd_en;
    rd1  = ch1_rd_en;
    acc  = enc_valid && enc_ready;
    word = {enc_chan, enc_sof, enc_eof, enc_data};
    if (stall_prev) check("hold_stable", 128'({enc_valid, word}), 128'({1'b1, stall_word}));
    stall_prev = enc_valid && !enc_ready;
    stall_word = word;
    if (rd1) saw_rd1 = 1'b1;
    if (acc) begin
      if (order.size() == 0) begin
        check("spurious_word", 128'(order.size()), 128'd1);
      end else begin
        ch = order[0];
        if (ch == 0) ed = (e0.size() != 0) ? e0.pop_front() : '1;
        else         ed = (e1.size() != 0) ? e1.pop_front() : '1;
        expw = {1'(ch), (widx == 0), (widx == FL - 1), ed};
        check("stream_word", 128'(word), 128'(expw));
        if (widx == 0) begin
          if (first_sof_cyc < 0) first_sof_cyc = cyc;
          if (last_eof_cyc >= 0) last_gap = cyc - last_eof_cyc - 1;
        end
        widx++;
        if (widx == FL) begin
          widx         = 0;
          last_eof_cyc = cyc;
          order.delete(0);
        end
      end
    end
    outstanding += int'(rd0) + int'(rd1) - int'(acc);
    check("outstanding", 128'(outstanding <= 3), 128'd1);
    @(posedge clk);
    #1;
    ch0_rd_valid = rd0;
    ch1_rd_valid = rd1;
    if (rd0) ch0_rd_data = (q0.size() != 0) ? q0.pop_front() : '1;
    if (rd1) ch1_rd_data = (q1.size() != 0) ? q1.pop_front() : '1;
    ch0_empty = (q0.size() == 0);
    ch1_empty = (q1.size() == 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_done(input string tag, input int budget);
    int n;
    n = 0;
    while (order.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 128'(order.size()), 128'd0);
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    ch0_rd_valid = 1'b0;
    ch1_rd_valid = 1'b0;
    q0.delete(); q1.delete(); e0.delete(); e1.delete(); order.delete();
    ch0_empty     = 1'b1;
    ch1_empty     = 1'b1;
    widx          = 0;
    outstanding   = 0;
    stall_prev    = 1'b0;
    first_sof_cyc = -1;
    last_eof_cyc  = -1;
    last_gap      = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] all_outputs();
    return 128'({enc_valid, enc_chan, enc_sof, enc_eof, busy, ch0_rd_en, ch1_rd_en,
                 enc_data, frames0_cnt, frames1_cnt});
  endfunction

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; outstanding = 0; widx = 0;
    first_sof_cyc = -1; last_eof_cyc = -1; last_gap = -1;
    saw_rd1 = 1'b0; stall_prev = 1'b0; stall_word = '0;
    rst_n = 1'b1; sched_en = 1'b0; enc_ready = 1'b0;
    ch0_empty = 1'b1; ch1_empty = 1'b1;
    ch0_rd_valid = 1'b0; ch1_rd_valid = 1'b0;
    ch0_rd_data = '0; ch1_rd_data = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_outputs", all_outputs(), 128'd0);
    apply_reset();

    // Single channel, two frames back to back.
    sched_en  = 1'b1;
    enc_ready = 1'b1;
    push_words(0, 32);
    order = '{0, 0};
    t0 = cyc;
    run_done("t1_done", 200);
    check("t1_first_latency", 128'(first_sof_cyc - t0), 128'd3);
    check("t1_gap", 128'(last_gap), 128'd3);
    check("t1_frames", 128'({frames0_cnt, frames1_cnt}), 128'({16'd2, 16'd0}));

    // Contention from reset: channel 0 wins first, then strict alternation.
    apply_reset();
    push_words(0, 48);
    push_words(1, 48);
    order = '{0, 1, 0, 1, 0, 1};
    run_done("t2_done", 400);
    check("t2_frames", 128'({frames0_cnt, frames1_cnt}), 128'({16'd3, 16'd3}));
    check("t2_gap", 128'(last_gap), 128'd3);

    // Random backpressure.
    push_words(0, 32);
    push_words(1, 32);
    order = '{0, 1, 0, 1};
    k = 0;
    while (order.size() != 0 && k < 2000) begin
      enc_ready = 1'($urandom_range(0, 1));
      cycle();
      k++;
    end
    enc_ready = 1'b1;
    check("t3_done", 128'(order.size()), 128'd0);
    check("t3_all_rx", 128'(e0.size() + e1.size()), 128'd0);
    check("t3_frames", 128'({frames0_cnt, frames1_cnt}), 128'({16'd5, 16'd5}));

    // Mid-frame starvation on channel 0.
    saw_rd1 = 1'b0;
    push_words(0, 10);
    push_words(1, 16);
    order = '{0, 1};
    repeat (40) cycle();
    check("t4_no_ch1_pop", 128'(saw_rd1), 128'd0);
    check("t4_held", 128'({busy, 8'(widx)}), 128'({1'b1, 8'd10}));
    check("t4_frames_hold", 128'(frames0_cnt), 128'd5);
    push_words(0, 6);
    run_done("t4_done", 200);
    check("t4_frames", 128'({frames0_cnt, frames1_cnt}), 128'({16'd6, 16'd6}));

    // Disable mid-frame: frame completes, then scheduler stays idle.
    push_words(0, 16);
    order = '{0};
    k = 0;
    while (widx < 5 && k < 20) begin
      cycle();
      k++;
    end
    sched_en = 1'b0;
    run_done("t5_done", 100);
    check("t5_idle_e1", 128'({busy, frames0_cnt}), 128'({1'b0, 16'd7}));
    cycle();
    check("t5_idle_e2", 128'(busy), 128'd0);
    saw_rd1 = 1'b0;
    push_words(1, 16);
    repeat (6) cycle();
    check("t5_stays_idle", 128'({busy, saw_rd1}), 128'd0);

    // Asynchronous reset in the middle of a channel-1 frame.
    order = '{1};
    sched_en = 1'b1;
    k = 0;
    while (widx < 8 && k < 30) begin
      cycle();
      k++;
    end
    check("t6_reached_word8", 128'(widx), 128'd8);
    rst_n = 1'b0;
    #1;
    check("t6_async_zero", all_outputs(), 128'd0);
    apply_reset();
    push_words(0, 16);
    push_words(1, 16);
    order = '{0, 1};
    run_done("t6_done", 200);
    check("t6_frames", 128'({frames0_cnt, frames1_cnt}), 128'({16'd1, 16'd1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/encoder_frame_sched.md
# encoder_frame_sched

Frame-granular round-robin scheduler sharing the single FEC encoder stage between two message buffers (channels 0 and 1).

- Pops whole frames of FRAME_LEN words from the selected channel's FIFO.
- Presents the words on a valid/ready stream to the encoder, tagged with channel and frame delimiters.
- Never interleaves words of different frames.

## Interface
- DATA_WIDTH, 32, word width (message_data_t)
- FRAME_LEN, 16, words per frame; legal 2..1024
- CNT_WIDTH, 16, width of per-channel frame counters

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset; one clock domain
- sched_en  in  1  enables new grants; a frame in progress always completes
- ch0_empty  in  1  channel-0 FIFO empty
- ch0_rd_en  out  1  channel-0 FIFO pop
- ch0_rd_data  in  DATA_WIDTH  channel-0 FIFO data
- ch0_rd_valid  in  1  ch0_rd_data valid; one cycle after an accepted ch0_rd_en
- ch1_empty, ch1_rd_en, ch1_rd_data, ch1_rd_valid: same as channel 0, for channel 1
- enc_valid  out  1  enc_data valid
- enc_ready  in  1  encoder accepts the word when enc_valid && enc_ready
- enc_data  out  DATA_WIDTH  word to encoder
- enc_chan  out  1  source channel of enc_data
- enc_sof  out  1  first word of frame
- enc_eof  out  1  last word of frame
- busy  out  1  state != IDLE
- frames0_cnt, frames1_cnt  out  CNT_WIDTH  frames completed per channel; wrap at 2^CNT_WIDTH

## Operation
The FSM has three states: IDLE, XFER, DRAIN.

IDLE:
- Grants when sched_en=1 and at least one chX_empty=0.
- If both channels are non-empty, grants the channel other than last_grant. Otherwise grants the non-empty one.
- Latches the granted channel into cur_chan, clears issued, and moves to XFER.

XFER:
- Asserts ch[cur_chan]_rd_en when all of the following hold:
  - ch[cur_chan]_empty = 0
  - issued < FRAME_LEN
  - occ + inflight − (enc_valid && enc_ready) < 2
- occ is the skid buffer occupancy (0..2). inflight is 1 if a pop was issued last cycle.
- The other channel's rd_en is always 0.
- issued increments on every rd_en. When issued reaches FRAME_LEN, the FSM moves to DRAIN.

Skid buffer:
- 2-entry FIFO holding {data, sof, eof, chan}.
- Written on ch[cur_chan]_rd_valid.
- sof is set when the word index is 0. eof is set when the word index is FRAME_LEN−1.
- Its head drives enc_*. enc_valid = (occ != 0).

DRAIN:
- Waits until the eof word is accepted by the encoder.
- In that same cycle: last_grant <= cur_chan, frames[cur_chan]_cnt increments, and the FSM moves to IDLE.

Boundary conditions:
- Source goes empty mid-frame: rd_en stalls and the grant is held indefinitely. There is no timeout and no switch to the other channel.
- enc_ready=0: enc_valid and enc_data stay stable until accepted. At most 2 words are buffered plus 1 in flight, so no word is ever dropped.
- sched_en deasserted in XFER or DRAIN: the frame finishes, then the FSM stays in IDLE.
- rd_valid arriving when not expected (no pop last cycle) is ignored.
- Reset mid-frame: the FSM returns to IDLE, the skid buffer is cleared, issued and inflight clear, and the partial frame is abandoned. FIFO contents are not restored.

## Timing
Reset values:
- All outputs are 0.
- FSM is in IDLE, occ=0, inflight=0.
- last_grant=1, so channel 0 wins the first contention.

Latencies:
- IDLE grant (cycle T) → first rd_en at T+1 → first enc_valid at T+3 (rd_valid at T+2, registered into the skid buffer).
- With enc_ready held at 1 and sources non-empty: one word per cycle. A FRAME_LEN frame occupies the stream for FRAME_LEN consecutive cycles.
- eof accepted at cycle E → IDLE at E+1 → next grant decision at E+1 → next first word at E+4. Inter-frame gap is 3 cycles.

Stream rules:
- enc_sof and enc_eof are only meaningful when enc_valid=1.
- enc_chan is constant for all words of a frame.

Counters:
- frames counters are registered and visible the cycle after eof acceptance.
- Wrap from 2^CNT_WIDTH−1 to 0.

## Test plan
- **Single channel:** FRAME_LEN=16, ch0 preloaded with 32 random words, ch1 empty, enc_ready=1.
  - 2 frames come out, all with chan=0, in FIFO order.
  - sof on words 0 and 16, eof on words 15 and 31.
  - frames0_cnt=2, 3-cycle gap between frames.
- **Contention:** both channels hold 3 frames.
  - Output frame order is ch0, ch1, ch0, ch1, ch0, ch1.
  - frames0_cnt = frames1_cnt = 3.
- **Backpressure:** enc_ready toggles randomly at 50%.
  - Every word is received exactly once, in order (scoreboard against per-channel queues).
  - enc_data is stable while enc_valid && !enc_ready.
  - rd_en is never asserted with occ + inflight = 2 and no drain.
- **Mid-frame starvation:** ch0 holds 10 words, ch1 holds 16.
  - Grant stays on ch0 and ch1_rd_en stays 0 until 6 more ch0 words are written.
  - The ch0 frame completes, then the ch1 frame follows.
- **Disable and reset:** deassert sched_en at word 5 of a frame.
  - The frame completes, and busy=0 two cycles after eof acceptance.
- **Reset mid-frame:** assert rst_n=0 at word 8.
  - All outputs are 0 immediately (asynchronous).
  - After release, channel 0 gets the first grant.
